dpram_banked: RTL and testbench

- Parametrised, byte-writable, dual-port block RAM bank for the picorv32 memory map.
- Generalises the fixed 2048x32 dual-port bank: data width, depth and bank-select width are parameters.
- Each port has a native valid/ready handshake with its own per-port FSM, so the bank attaches directly to the CPU bus (port A) and to a second master such as a loader or DMA (port B).
- One clock domain. The address decoder is built in, so several instances with different BLKSEL share a bus.

---
 rtl/dpram_banked.sv | 133 +++++++++++++
 tb/tb_dpram_banked.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dpram_banked.sv
// dpram_banked: byte-writable dual-port RAM bank with a valid/ready handshake
// on each port. There is a built-in bank decoder, so several instances with
// different BLKSEL values can share one bus.
//
// Ports (x = a | b, two identical ports):
//   clk, resetn          clock; asynchronous active-low reset
//   x_valid              request, held by the master until x_ready
//   x_addr[ADDR_WIDTH]   byte address; the top BLK_BITS select the bank
//   x_wstrb[NB]          byte write enables; all zero means a read
//   x_wdata[DATA_WIDTH]  write data
//   x_ready              one-cycle acknowledge
//   x_rdata[DATA_WIDTH]  read-first data; valid while x_ready is high
//
// Optional macro DPRAM_OUTREG_EN adds an output register after the array.
// With it, each port steps IDLE -> WAIT -> ACK and the latency is 2 clocks.
// Without it, each port steps IDLE -> ACK and the latency is 1 clock.
module dpram_banked #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048,
   parameter int ADDR_WIDTH = 16,
   parameter int BLK_BITS   = 3,
   parameter int BLKSEL     = 0
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      a_valid,
   input  logic [ADDR_WIDTH-1:0]     a_addr,
   input  logic [DATA_WIDTH/8-1:0]   a_wstrb,
   input  logic [DATA_WIDTH-1:0]     a_wdata,
   output logic                      a_ready,
   output logic [DATA_WIDTH-1:0]     a_rdata,
   input  logic                      b_valid,
   input  logic [ADDR_WIDTH-1:0]     b_addr,
   input  logic [DATA_WIDTH/8-1:0]   b_wstrb,
   input  logic [DATA_WIDTH-1:0]     b_wdata,
   output logic                      b_ready,
   output logic [DATA_WIDTH-1:0]     b_rdata
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int WW = $clog2(DEPTH);
   localparam int BW = $clog2(NB);
   localparam logic [BLK_BITS-1:0] BSEL = BLK_BITS'(BLKSEL);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Port 0 = A, port 1 = B.
   logic [1:0]                 vld, sel, acc, rdy;
   logic [1:0][ADDR_WIDTH-1:0] addr;
   logic [1:0][NB-1:0]         wstrb;
   logic [1:0][DATA_WIDTH-1:0] wdata, rdata;
   logic [1:0][WW-1:0]         idx;

   assign vld   = {b_valid, a_valid};
   assign addr  = {b_addr,  a_addr};
   assign wstrb = {b_wstrb, a_wstrb};
   assign wdata = {b_wdata, a_wdata};
   assign a_ready = rdy[0];
   assign b_ready = rdy[1];
   assign a_rdata = rdata[0];
   assign b_rdata = rdata[1];

   // The byte-offset bits do not take part in word selection.
   if (BW > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^{a_addr[BW-1:0], b_addr[BW-1:0]};
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      state_t                state;
      logic                  rdy_q;
      logic [DATA_WIDTH-1:0] rdata_q;
`ifdef DPRAM_OUTREG_EN
      logic [DATA_WIDTH-1:0] arr_q;
`endif

      assign idx[p]   = addr[p][BW +: WW];
      assign sel[p]   = vld[p] && (addr[p][ADDR_WIDTH-1 -: BLK_BITS] == BSEL);
      // A request is taken only in IDLE, so a request held through ACK is
      // never accepted twice.
      assign acc[p]   = sel[p] && (state == S_IDLE);
      assign rdy[p]   = rdy_q;
      assign rdata[p] = rdata_q;

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            state   <= S_IDLE;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
`ifdef DPRAM_OUTREG_EN
            arr_q   <= '0;
`endif
         end else begin
            case (state)
               S_IDLE: if (sel[p]) begin
`ifdef DPRAM_OUTREG_EN
                  state   <= S_WAIT;
                  arr_q   <= mem[idx[p]];   // read-first: old word
`else
                  state   <= S_ACK;
                  rdy_q   <= 1'b1;
                  rdata_q <= mem[idx[p]];   // read-first: old word
`endif
               end
               S_WAIT: begin
                  state   <= S_ACK;
                  rdy_q   <= 1'b1;
`ifdef DPRAM_OUTREG_EN
                  rdata_q <= arr_q;
`endif
               end
               default: begin                // S_ACK
                  state <= S_IDLE;
                  rdy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Writes commit on the accept edge. Port B is assigned first, so on a
   // lane that both ports strobe in the same word, port A's later
   // nonblocking assignment wins.
   always_ff @(posedge clk) begin
      if (resetn) begin
         for (int i = 0; i < NB; i++) begin
            if (acc[1] && wstrb[1][i]) mem[idx[1]][8*i +: 8] <= wdata[1][8*i +: 8];
            if (acc[0] && wstrb[0][i]) mem[idx[0]][8*i +: 8] <= wdata[0][8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dpram_banked.sv
// Testbench for dpram_banked (default parameters, BLKSEL = 0).
// The driver pushes the expected read-first data into per-port queues.
// A negedge monitor pops one entry and compares it each time a port acknowledges.
module tb_dpram_banked;
   localparam int DW = 32;
`ifdef DPRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic [15:0]   a_addr = '0, b_addr = '0;
   logic [3:0]    a_wstrb = '0, b_wstrb = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_ready, b_ready;
   logic [DW-1:0] a_rdata, b_rdata;

   dpram_banked dut (
      .clk(clk), .resetn(resetn),
      .a_valid(a_valid), .a_addr(a_addr), .a_wstrb(a_wstrb), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_addr(b_addr), .b_wstrb(b_wstrb), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_rdata(b_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {bit chk; logic [31:0] val;} exp_t;
   exp_t qa[$], qb[$];
   logic [31:0] mdl [int];   // word index -> contents, only words ever written
   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit in_bank(input logic [15:0] a);
      return a[15:13] == 3'd0;
   endfunction

   function automatic int word_of(input logic [15:0] a);
      return int'(a[12:2]);
   endfunction

   function automatic exp_t expect_of(input int w);
      exp_t e;
      e.chk = mdl.exists(w);
      e.val = e.chk ? mdl[w] : 32'h0;
      return e;
   endfunction

   task automatic apply_wr(input int w, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] v;
      v = mdl.exists(w) ? mdl[w] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      if (s != 4'h0) mdl[w] = v;
   endtask

   // Issue one request on A and/or B in the same cycle, then watch 10 cycles.
   task automatic xfer(input bit ae, input logic [15:0] aa, input logic [3:0] as, input logic [31:0] ad,
                       input bit be, input logic [15:0] ba, input logic [3:0] bs, input logic [31:0] bd);
      bit ia, ib;
      int la, lb;
      @(negedge clk);
      ia = ae && in_bank(aa);
      ib = be && in_bank(ba);
      if (ia) qa.push_back(expect_of(word_of(aa)));
      if (ib) qb.push_back(expect_of(word_of(ba)));
      // Both reads see the old word; on a shared lane A's data lands last.
      if (ib) apply_wr(word_of(ba), bs, bd);
      if (ia) apply_wr(word_of(aa), as, ad);
      a_valid = ae; a_addr = aa; a_wstrb = as; a_wdata = ad;
      b_valid = be; b_addr = ba; b_wstrb = bs; b_wdata = bd;
      la = 0; lb = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (a_ready) begin
            if (ia && la == 0) la = c;
            else check("a_ready_extra", 32'(a_ready), 32'h0);
         end
         if (b_ready) begin
            if (ib && lb == 0) lb = c;
            else check("b_ready_extra", 32'(b_ready), 32'h0);
         end
         @(negedge clk);
         if (la != 0) a_valid = 1'b0;
         if (lb != 0) b_valid = 1'b0;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      if (ia) check("a_latency", 32'(la), 32'(LAT));
      if (ib) check("b_latency", 32'(lb), 32'(LAT));
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (resetn && a_ready) begin
         if (qa.size() == 0) check("a_ready_unexpected", 32'(a_ready), 32'h0);
         else begin
            e = qa.pop_front();
            if (e.chk) check("a_rdata", a_rdata, e.val);
         end
      end
      if (resetn && b_ready) begin
         if (qb.size() == 0) check("b_ready_unexpected", 32'(b_ready), 32'h0);
         else begin
            e = qb.pop_front();
            if (e.chk) check("b_rdata", b_rdata, e.val);
         end
      end
   end

   initial begin
      int got;
      logic [15:0] ra, rb;
      #12;
      check("rst_a_ready", 32'(a_ready), 32'h0);
      check("rst_b_ready", 32'(b_ready), 32'h0);
      check("rst_a_rdata", a_rdata, 32'h0);
      check("rst_b_rdata", b_rdata, 32'h0);
      @(negedge clk); resetn = 1'b1;

      // Full write, read back, partial write, read back
      xfer(1, 16'h0010, 4'hF, 32'hDEADBEEF, 0, 16'h0, 4'h0, 32'h0);
      xfer(1, 16'h0010, 4'h0, 32'h0,        0, 16'h0, 4'h0, 32'h0);
      xfer(1, 16'h0010, 4'b0100, 32'h00AA0000, 0, 16'h0, 4'h0, 32'h0);
      xfer(1, 16'h0013, 4'h0, 32'h0,        0, 16'h0, 4'h0, 32'h0);
      // Another bank's address: no ready, no write
      xfer(1, 16'h2010, 4'hF, 32'hFFFFFFFF, 0, 16'h0, 4'h0, 32'h0);
      xfer(1, 16'h0010, 4'h0, 32'h0,        0, 16'h0, 4'h0, 32'h0);
      // Write/write collision on one word, then readback on B
      xfer(1, 16'h0020, 4'h3, 32'h11111111, 1, 16'h0020, 4'hE, 32'h22222222);
      xfer(0, 16'h0, 4'h0, 32'h0,           1, 16'h0020, 4'h0, 32'h0);
      // Read/write collision on word 0x40
      xfer(0, 16'h0, 4'h0, 32'h0,           1, 16'h0100, 4'hF, 32'h12345678);
      xfer(1, 16'h0100, 4'h0, 32'h0,        1, 16'h0100, 4'hF, 32'h55555555);
      xfer(1, 16'h0100, 4'h0, 32'h0,        0, 16'h0, 4'h0, 32'h0);

      // Reset during ACK: ready and rdata clear at once, memory is kept
      @(negedge clk);
      a_addr = 16'h0100; a_wstrb = 4'h0; a_valid = 1'b1;
      got = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (a_ready) begin got = c; break; end
      end
      check("rstack_latency", 32'(got), 32'(LAT));
      check("rstack_rdata", a_rdata, mdl[64]);
      resetn = 1'b0;
      #1;
      check("rstack_a_ready", 32'(a_ready), 32'h0);
      check("rstack_a_rdata", a_rdata, 32'h0);
      a_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      xfer(1, 16'h0100, 4'h0, 32'h0, 0, 16'h0, 4'h0, 32'h0);

      // Random traffic over 16 words plus some accesses to other banks
      for (int w = 0; w < 16; w++)
         xfer(0, 16'h0, 4'h0, 32'h0, 1, 16'(w * 4), 4'hF, $urandom);
      for (int n = 0; n < 300; n++) begin
         ra = {($urandom_range(0, 7) == 0) ? 3'(3'($urandom_range(1, 7))) : 3'd0,
               11'($urandom_range(0, 15)), 2'($urandom)};
         rb = {($urandom_range(0, 7) == 0) ? 3'(3'($urandom_range(1, 7))) : 3'd0,
               11'($urandom_range(0, 15)), 2'($urandom)};
         xfer($urandom_range(0, 3) != 0, ra, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom,
              $urandom_range(0, 3) != 0, rb, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom);
      end

      check("a_queue_drained", 32'(qa.size()), 32'h0);
      check("b_queue_drained", 32'(qb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
